// File: rtl/controle_jogo.sv
// rtl/controle_jogo.sv - battleship game control: mode FSM, target coordinates, lives, hits and digit-scan counter.
module controle_jogo #(
  parameter int DIV_SCAN = 50000,
  parameter int N_COL    = 5,
  parameter int N_LIN    = 5,
  parameter int VIDA_INI = 5,
  parameter int N_ALVOS  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       liga,
  input  logic       btn_confirma,
  input  logic       btn_col,
  input  logic       btn_lin,
  input  logic [2:0] sel_mapa,
  input  logic       celula_navio,
  output logic [1:0] contador,
  output logic       ATAQUE,
  output logic       PREPARACAO,
  output logic       DESLIGADO,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic [2:0] mapa,
  output logic [2:0] vida,
  output logic       vitoria,
  output logic       derrota
);

  localparam int NCEL = N_COL * N_LIN;
  localparam int IW   = (NCEL > 1) ? $clog2(NCEL) : 1;
  localparam int HW   = $clog2(N_ALVOS + 1);
  localparam int PW   = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;

  typedef enum logic [1:0] {S_DESL, S_PREP, S_ATQ, S_FIM} estado_t;

  estado_t         state;
  estado_t         state_next;
  logic [PW-1:0]   presc;
  logic [NCEL-1:0] bitmap;
  logic [HW-1:0]   hits;
  logic [IW-1:0]   idx;
  logic            tiro;
  logic            fim_vit;
  logic            fim_der;

  // A shot only counts on a cell not yet in the bitmap; it uses the pre-move coordinates.
  assign idx     = IW'(coordLinha) * IW'(N_COL) + IW'(coordColuna);
  assign tiro    = (state == S_ATQ) && btn_confirma && !bitmap[idx];
  assign fim_vit = tiro && celula_navio && (hits == HW'(N_ALVOS - 1));
  assign fim_der = tiro && !celula_navio && (vida <= 3'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_DESL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!liga) begin
      state_next = S_DESL;
    end else begin
      case (state)
        S_DESL: state_next = S_PREP;
        S_PREP: if (btn_confirma) state_next = S_ATQ;
        S_ATQ:  if (fim_vit || fim_der) state_next = S_FIM;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    DESLIGADO  = 1'b0;
    PREPARACAO = 1'b0;
    ATAQUE     = 1'b0;
    case (state)
      S_DESL:  DESLIGADO  = 1'b1;
      S_PREP:  PREPARACAO = 1'b1;
      default: ATAQUE     = 1'b1;
    endcase
  end

  // Digit scan keeps running regardless of the game state.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      contador <= 2'd0;
    end else if (presc == PW'(DIV_SCAN - 1)) begin
      presc    <= '0;
      contador <= contador + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coordColuna <= 3'd0;
      coordLinha  <= 3'd0;
      mapa        <= 3'd0;
      vida        <= 3'd0;
      vitoria     <= 1'b0;
      derrota     <= 1'b0;
      bitmap      <= '0;
      hits        <= '0;
    end else if (!liga) begin
      coordColuna <= 3'd0;
      coordLinha  <= 3'd0;
      vida        <= 3'd0;
      vitoria     <= 1'b0;
      derrota     <= 1'b0;
      bitmap      <= '0;
      hits        <= '0;
    end else begin
      case (state)
        S_PREP: begin
          mapa <= sel_mapa;
          if (btn_confirma) begin
            vida        <= 3'(VIDA_INI);
            coordColuna <= 3'd0;
            coordLinha  <= 3'd0;
            vitoria     <= 1'b0;
            derrota     <= 1'b0;
            bitmap      <= '0;
            hits        <= '0;
          end
        end
        S_ATQ: begin
          if (tiro) begin
            bitmap[idx] <= 1'b1;
            if (celula_navio) begin
              hits <= hits + HW'(1);
              if (fim_vit) vitoria <= 1'b1;
            end else begin
              if (vida != 3'd0) vida <= vida - 3'd1;
              if (fim_der) derrota <= 1'b1;
            end
          end
          if (btn_col)
            coordColuna <= (coordColuna == 3'(N_COL - 1)) ? 3'd0 : coordColuna + 3'd1;
          if (btn_lin)
            coordLinha <= (coordLinha == 3'(N_LIN - 1)) ? 3'd0 : coordLinha + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_jogo.sv
// tb/tb_controle_jogo.sv - self-checking bench for controle_jogo against a behavioural game model.
module tb_controle_jogo;

  logic       clk = 1'b0;
  logic       reset, liga, btn_confirma, btn_col, btn_lin, celula_navio;
  logic [2:0] sel_mapa;
  logic [1:0] contador;
  logic       ATAQUE, PREPARACAO, DESLIGADO;
  logic [2:0] coordColuna, coordLinha, mapa, vida;
  logic       vitoria, derrota;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the game: mode 0=off 1=setup 2=attack 3=over
  int m_mode, m_col, m_lin, m_mapa, m_vida, m_hits, m_cyc;
  bit m_vit, m_der;
  bit m_shot[25];

  controle_jogo #(.DIV_SCAN(4)) dut (
    .clk(clk), .reset(reset), .liga(liga), .btn_confirma(btn_confirma),
    .btn_col(btn_col), .btn_lin(btn_lin), .sel_mapa(sel_mapa),
    .celula_navio(celula_navio), .contador(contador), .ATAQUE(ATAQUE),
    .PREPARACAO(PREPARACAO), .DESLIGADO(DESLIGADO), .coordColuna(coordColuna),
    .coordLinha(coordLinha), .mapa(mapa), .vida(vida), .vitoria(vitoria),
    .derrota(derrota)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_col = 0; m_lin = 0; m_vida = 0; m_hits = 0; m_vit = 0; m_der = 0;
    foreach (m_shot[i]) m_shot[i] = 0;
  endtask

  task automatic model_step(input bit r, l, c, bc, bl, input int s, input bit cel);
    int k;
    if (r) begin
      model_clear();
      m_mode = 0; m_mapa = 0; m_cyc = 0;
      return;
    end
    m_cyc++;
    if (!l) begin
      m_mode = 0;
      model_clear();
      return;
    end
    case (m_mode)
      0: m_mode = 1;
      1: begin
        m_mapa = s;
        if (c) begin
          model_clear();
          m_vida = 5;
          m_mode = 2;
        end
      end
      2: begin
        k = m_lin * 5 + m_col;
        if (c && !m_shot[k]) begin
          m_shot[k] = 1;
          if (cel) begin
            m_hits++;
            if (m_hits == 6) begin m_vit = 1; m_mode = 3; end
          end else begin
            if (m_vida > 0) m_vida--;
            if (m_vida == 0) begin m_der = 1; m_mode = 3; end
          end
        end
        if (bc) m_col = (m_col + 1) % 5;
        if (bl) m_lin = (m_lin + 1) % 5;
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_eq("flags", {ATAQUE, PREPARACAO, DESLIGADO},
             {m_mode >= 2, m_mode == 1, m_mode == 0});
    check_eq("contador", contador, (m_cyc / 4) % 4);
    check_eq("col", coordColuna, m_col);
    check_eq("lin", coordLinha, m_lin);
    check_eq("mapa", mapa, m_mapa);
    check_eq("vida", vida, m_vida);
    check_eq("vit_der", {vitoria, derrota}, {m_vit, m_der});
  endtask

  task automatic step(input bit r, l, c, bc, bl, input logic [2:0] s, input bit cel);
    @(negedge clk);
    reset = r; liga = l; btn_confirma = c; btn_col = bc; btn_lin = bl;
    sel_mapa = s; celula_navio = cel;
    @(posedge clk);
    model_step(r, l, c, bc, bl, int'(s), cel);
    #1;
    compare_all();
  endtask

  int exp_col[5] = '{1, 2, 3, 4, 0};

  initial begin
    reset = 1; liga = 1; btn_confirma = 0; btn_col = 0; btn_lin = 0;
    sel_mapa = 0; celula_navio = 0;

    step(1, 1, 0, 0, 0, 3'd0, 0);
    step(1, 1, 0, 0, 0, 3'd0, 0);
    check_eq("rst_desl", DESLIGADO, 1);
    check_eq("rst_cont", contador, 0);
    check_eq("rst_vida", vida, 0);
    check_eq("rst_coords", {coordColuna, coordLinha}, 0);
    check_eq("rst_vd", {vitoria, derrota}, 0);

    step(0, 1, 0, 0, 0, 3'd3, 0);
    check_eq("prep", PREPARACAO, 1);
    step(0, 1, 0, 1, 1, 3'd3, 0);
    check_eq("mapa_track", mapa, 3);
    check_eq("prep_no_move", {coordColuna, coordLinha}, 0);
    step(0, 1, 1, 0, 0, 3'd3, 0);
    check_eq("atq", ATAQUE, 1);
    check_eq("vida_ini", vida, 5);
    step(0, 1, 0, 0, 0, 3'd6, 0);
    check_eq("mapa_frozen", mapa, 3);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, 0, 3'd6, 0);
      check_eq("col_wrap", coordColuna, exp_col[i]);
    end
    step(0, 1, 0, 1, 1, 3'd6, 0);
    check_eq("col_lin_both", {coordColuna, coordLinha}, {3'd1, 3'd1});

    step(0, 1, 1, 0, 0, 3'd6, 0);
    check_eq("miss1", vida, 4);
    step(0, 1, 1, 0, 0, 3'd6, 0);
    check_eq("dup_shot", vida, 4);
    step(0, 1, 0, 1, 0, 3'd6, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 1, 0, 3'd6, 0);
      check_eq("miss_seq", vida, 3 - i);
    end
    check_eq("derrota", derrota, 1);
    step(0, 1, 1, 1, 1, 3'd6, 1);
    step(0, 1, 1, 1, 1, 3'd6, 0);
    check_eq("fim_hold", {coordColuna, coordLinha, vida}, {3'd1, 3'd1, 3'd0});
    check_eq("fim_atq", ATAQUE, 1);

    step(0, 0, 0, 0, 0, 3'd6, 0);
    check_eq("off_desl", DESLIGADO, 1);
    check_eq("off_mapa", mapa, 3);
    step(0, 1, 0, 0, 0, 3'd2, 0);
    step(0, 1, 1, 0, 0, 3'd2, 1);
    check_eq("mapa2", mapa, 2);
    step(0, 1, 1, 1, 0, 3'd2, 1);
    check_eq("shot_then_move", coordColuna, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 3'd2, 1);
    step(0, 1, 1, 1, 1, 3'd2, 1);
    check_eq("no_win_yet", vitoria, 0);
    step(0, 1, 1, 0, 0, 3'd2, 1);
    check_eq("vitoria", vitoria, 1);
    check_eq("vit_vida", vida, 5);

    step(0, 0, 0, 0, 0, 3'd2, 0);
    step(0, 1, 0, 0, 0, 3'd5, 0);
    step(0, 1, 1, 0, 0, 3'd5, 0);
    step(0, 1, 1, 1, 0, 3'd5, 0);
    step(0, 0, 0, 0, 0, 3'd5, 0);
    check_eq("midgame_off", DESLIGADO, 1);
    check_eq("midgame_vida", vida, 0);

    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 149) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
